imuldiv_muldiv_tracker: RTL and testbench

IMULDIV_MULDIV_TRACKER -- requirements
Module: imuldiv_muldiv_tracker

---
 rtl/imuldiv_pkg.sv | 28 ++
 rtl/imuldiv_tag_fifo.sv | 53 +++++
 rtl/imuldiv_muldiv_tracker.sv | 101 ++++++++++
 tb/tb_imuldiv_muldiv_tracker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_pkg.sv
// Shared mul/div definitions: operation codes and which half of the 64-bit
// unit result carries the architectural answer for each operation.
package imuldiv_pkg;

    typedef enum logic [2:0] {
        FN_MUL  = 3'd0,
        FN_DIV  = 3'd1,
        FN_DIVU = 3'd2,
        FN_REM  = 3'd3,
        FN_REMU = 3'd4
    } muldiv_fn_e;

    // LO holds the product or quotient, HI holds the remainder.
    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } result_half_e;

    function automatic result_half_e result_half(input logic [2:0] fn);
        result_half_e half;
        case (muldiv_fn_e'(fn))
            FN_REM, FN_REMU: half = HALF_HI;
            default:         half = HALF_LO;
        endcase
        return half;
    endfunction

endpackage

// File: rtl/imuldiv_tag_fifo.sv
// In-order record store for outstanding mul/div requests ({fn, tag} entries).
// Storage is unreset; it is only read while the FIFO holds entries.
module imuldiv_tag_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/imuldiv_muldiv_tracker.sv
// Tracks in-flight mul/div requests: forwards operands to the unit, remembers
// {fn, tag} per request, and turns each 64-bit unit result into a tagged 32-bit response.
module imuldiv_muldiv_tracker
    import imuldiv_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [2:0]       cpureq_msg_fn,
    input  logic [31:0]      cpureq_msg_a,
    input  logic [31:0]      cpureq_msg_b,
    input  logic [TAG_W-1:0] cpureq_msg_tag,
    input  logic             cpureq_val,
    output logic             cpureq_rdy,

    output logic [2:0]       muldivreq_msg_fn,
    output logic [31:0]      muldivreq_msg_a,
    output logic [31:0]      muldivreq_msg_b,
    output logic             muldivreq_val,
    input  logic             muldivreq_rdy,

    input  logic [63:0]      muldivresp_msg_result,
    input  logic             muldivresp_val,
    output logic             muldivresp_rdy,

    output logic [31:0]      cpuresp_msg_result,
    output logic [TAG_W-1:0] cpuresp_msg_tag,
    output logic             cpuresp_val,
    input  logic             cpuresp_rdy,

    output logic             err_orphan
);

    localparam int REC_W = 3 + TAG_W;

    // All handshakes: a transfer happens on a rising edge where val && rdy.
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [REC_W-1:0] head;
    logic [2:0]       head_fn;
    logic [TAG_W-1:0] head_tag;
    logic [31:0]      sel_result;

    assign muldivreq_msg_fn = cpureq_msg_fn;
    assign muldivreq_msg_a  = cpureq_msg_a;
    assign muldivreq_msg_b  = cpureq_msg_b;
    assign muldivreq_val    = cpureq_val && !full;
    assign cpureq_rdy       = muldivreq_rdy && !full;
    assign push             = cpureq_val && cpureq_rdy;

    // Accept a unit response only when the output register is free or draining.
    assign muldivresp_rdy = !empty && (!cpuresp_val || cpuresp_rdy);
    assign pop            = muldivresp_val && muldivresp_rdy;

    imuldiv_tag_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({cpureq_msg_fn, cpureq_msg_tag}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign head_fn    = head[REC_W-1 -: 3];
    assign head_tag   = head[TAG_W-1:0];
    assign sel_result = (result_half(head_fn) == HALF_HI) ? muldivresp_msg_result[63:32]
                                                          : muldivresp_msg_result[31:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpuresp_val        <= 1'b0;
            cpuresp_msg_result <= '0;
            cpuresp_msg_tag    <= '0;
        end else if (pop) begin
            cpuresp_val        <= 1'b1;
            cpuresp_msg_result <= sel_result;
            cpuresp_msg_tag    <= head_tag;
        end else if (cpuresp_rdy) begin
            cpuresp_val <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_orphan <= 1'b0;
        end else if (muldivresp_val && empty) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imuldiv_muldiv_tracker.sv
// Directed bench for imuldiv_muldiv_tracker: vector table of single transactions
// followed by hand-written fill, stall, orphan and reset sequences.
module tb_imuldiv_muldiv_tracker;
    import imuldiv_pkg::*;

    localparam int TAG_W = 5;
    localparam int DEPTH = 2;

    logic             clk;
    logic             reset;
    logic [2:0]       cpureq_msg_fn;
    logic [31:0]      cpureq_msg_a;
    logic [31:0]      cpureq_msg_b;
    logic [TAG_W-1:0] cpureq_msg_tag;
    logic             cpureq_val;
    logic             cpureq_rdy;
    logic [2:0]       muldivreq_msg_fn;
    logic [31:0]      muldivreq_msg_a;
    logic [31:0]      muldivreq_msg_b;
    logic             muldivreq_val;
    logic             muldivreq_rdy;
    logic [63:0]      muldivresp_msg_result;
    logic             muldivresp_val;
    logic             muldivresp_rdy;
    logic [31:0]      cpuresp_msg_result;
    logic [TAG_W-1:0] cpuresp_msg_tag;
    logic             cpuresp_val;
    logic             cpuresp_rdy;
    logic             err_orphan;

    int n_tests = 0;
    int n_fail  = 0;

    imuldiv_muldiv_tracker #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .cpureq_msg_fn         (cpureq_msg_fn),
        .cpureq_msg_a          (cpureq_msg_a),
        .cpureq_msg_b          (cpureq_msg_b),
        .cpureq_msg_tag        (cpureq_msg_tag),
        .cpureq_val            (cpureq_val),
        .cpureq_rdy            (cpureq_rdy),
        .muldivreq_msg_fn      (muldivreq_msg_fn),
        .muldivreq_msg_a       (muldivreq_msg_a),
        .muldivreq_msg_b       (muldivreq_msg_b),
        .muldivreq_val         (muldivreq_val),
        .muldivreq_rdy         (muldivreq_rdy),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy),
        .cpuresp_msg_result    (cpuresp_msg_result),
        .cpuresp_msg_tag       (cpuresp_msg_tag),
        .cpuresp_val           (cpuresp_val),
        .cpuresp_rdy           (cpuresp_rdy),
        .err_orphan            (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       fn;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [63:0]      unit_res;
        logic [31:0]      exp_res;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag);
        cpureq_val     = 1'b1;
        cpureq_msg_fn  = fn;
        cpureq_msg_a   = a;
        cpureq_msg_b   = b;
        cpureq_msg_tag = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{FN_MUL,  32'd7,  32'd6, 5'd3,  64'h0000_0000_0000_002A, 32'h0000_002A};
        vecs[1] = '{FN_REM,  32'd17, 32'd5, 5'd9,  64'h0000_0002_0000_0003, 32'h0000_0002};
        vecs[2] = '{FN_DIV,  32'd17, 32'd5, 5'd10, 64'h0000_0002_0000_0003, 32'h0000_0003};
        vecs[3] = '{FN_MUL,  32'h1000_0000, 32'h10, 5'd31, 64'h0000_0001_0000_0000, 32'h0000_0000};
        vecs[4] = '{FN_DIVU, 32'hFFFF_FFFF, 32'd2, 5'd0, 64'h0000_0001_7FFF_FFFF, 32'h7FFF_FFFF};
        vecs[5] = '{FN_REMU, 32'hFFFF_FFFF, 32'd2, 5'd17, 64'h0000_0001_7FFF_FFFF, 32'h0000_0001};

        reset                 = 1'b0;
        cpureq_val            = 1'b0;
        cpureq_msg_fn         = '0;
        cpureq_msg_a          = '0;
        cpureq_msg_b          = '0;
        cpureq_msg_tag        = '0;
        muldivreq_rdy         = 1'b1;
        muldivresp_val        = 1'b0;
        muldivresp_msg_result = '0;
        cpuresp_rdy           = 1'b1;

        // Reset state
        #3;
        check("rst_cpuresp_val", cpuresp_val, 0);
        check("rst_cpuresp_result", cpuresp_msg_result, 0);
        check("rst_cpuresp_tag", cpuresp_msg_tag, 0);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_muldivresp_rdy", muldivresp_rdy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single transactions from the vector table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_req(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].tag);
            #1;
            check("vec_cpureq_rdy", cpureq_rdy, 1);
            check("vec_muldivreq_val", muldivreq_val, 1);
            check("vec_fwd_fn", muldivreq_msg_fn, vecs[i].fn);
            check("vec_fwd_a", muldivreq_msg_a, vecs[i].a);
            check("vec_fwd_b", muldivreq_msg_b, vecs[i].b);
            @(negedge clk);
            cpureq_val            = 1'b0;
            muldivresp_val        = 1'b1;
            muldivresp_msg_result = vecs[i].unit_res;
            #1;
            check("vec_muldivresp_rdy", muldivresp_rdy, 1);
            check("vec_cpuresp_val_before", cpuresp_val, 0);
            @(posedge clk);
            #1;
            check("vec_cpuresp_val", cpuresp_val, 1);
            check("vec_result", cpuresp_msg_result, vecs[i].exp_res);
            check("vec_tag", cpuresp_msg_tag, vecs[i].tag);
            @(negedge clk);
            muldivresp_val = 1'b0;
            @(posedge clk);
            #1;
            check("vec_cpuresp_drain", cpuresp_val, 0);
        end
        check("vec_no_orphan", err_orphan, 0);

        // Fill to DEPTH with responses withheld; third request waits for the first pop
        @(negedge clk);
        set_req(FN_MUL, 32'd1, 32'd5, 5'd1);
        @(negedge clk);
        set_req(FN_DIV, 32'd9, 32'd2, 5'd2);
        @(negedge clk);
        set_req(FN_REM, 32'd9, 32'd0, 5'd3);
        #1;
        check("full_cpureq_rdy", cpureq_rdy, 0);
        check("full_muldivreq_val", muldivreq_val, 0);
        muldivresp_val        = 1'b1;
        muldivresp_msg_result = 64'h0000_0000_0000_0005;
        #1;
        check("full_muldivresp_rdy", muldivresp_rdy, 1);
        check("full_cpureq_rdy_pop_cycle", cpureq_rdy, 0);
        @(posedge clk);
        #1;
        check("full_pop1_val", cpuresp_val, 1);
        check("full_pop1_result", cpuresp_msg_result, 32'h5);
        check("full_pop1_tag", cpuresp_msg_tag, 5'd1);
        @(negedge clk);
        muldivresp_val = 1'b0;
        #1;
        check("full_cpureq_rdy_after_pop", cpureq_rdy, 1);
        check("full_muldivreq_val_after_pop", muldivreq_val, 1);
        @(negedge clk);
        cpureq_val            = 1'b0;
        muldivresp_val        = 1'b1;
        muldivresp_msg_result = 64'h0000_0001_0000_0004;
        @(posedge clk);
        #1;
        check("b2b_1_result", cpuresp_msg_result, 32'h4);
        check("b2b_1_tag", cpuresp_msg_tag, 5'd2);
        @(negedge clk);
        muldivresp_msg_result = 64'h0000_0009_0000_0000;
        #1;
        check("b2b_muldivresp_rdy", muldivresp_rdy, 1);
        @(posedge clk);
        #1;
        check("b2b_2_val", cpuresp_val, 1);
        check("b2b_2_result", cpuresp_msg_result, 32'h9);
        check("b2b_2_tag", cpuresp_msg_tag, 5'd3);
        @(negedge clk);
        muldivresp_val = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_drain", cpuresp_val, 0);

        // Output stall for 3 cycles, then release with the next response waiting
        @(negedge clk);
        cpuresp_rdy = 1'b0;
        set_req(FN_MUL, 32'd3, 32'd3, 5'd4);
        @(negedge clk);
        set_req(FN_MUL, 32'd4, 32'd4, 5'd5);
        @(negedge clk);
        cpureq_val            = 1'b0;
        muldivresp_val        = 1'b1;
        muldivresp_msg_result = 64'h0000_0000_0000_0011;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            muldivresp_msg_result = 64'h0000_0000_0000_0022;
            #1;
            check("stall_muldivresp_rdy", muldivresp_rdy, 0);
            check("stall_val", cpuresp_val, 1);
            check("stall_result", cpuresp_msg_result, 32'h11);
            check("stall_tag", cpuresp_msg_tag, 5'd4);
        end
        @(negedge clk);
        cpuresp_rdy = 1'b1;
        #1;
        check("release_muldivresp_rdy", muldivresp_rdy, 1);
        @(posedge clk);
        #1;
        check("release_val", cpuresp_val, 1);
        check("release_result", cpuresp_msg_result, 32'h22);
        check("release_tag", cpuresp_msg_tag, 5'd5);
        @(negedge clk);
        muldivresp_val = 1'b0;
        @(posedge clk);
        #1;
        check("release_drain", cpuresp_val, 0);

        // Orphan response while empty
        @(negedge clk);
        muldivresp_val        = 1'b1;
        muldivresp_msg_result = 64'hDEAD_BEEF_0000_0001;
        #1;
        check("orphan_muldivresp_rdy", muldivresp_rdy, 0);
        check("orphan_flag_before", err_orphan, 0);
        @(posedge clk);
        #1;
        check("orphan_flag_set", err_orphan, 1);
        check("orphan_no_output", cpuresp_val, 0);
        @(negedge clk);
        muldivresp_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("orphan_flag_sticky", err_orphan, 1);

        // Asynchronous reset with two records outstanding and a held output
        @(negedge clk);
        cpuresp_rdy = 1'b0;
        set_req(FN_DIV, 32'd8, 32'd2, 5'd6);
        @(negedge clk);
        set_req(FN_REM, 32'd8, 32'd3, 5'd7);
        @(negedge clk);
        cpureq_val            = 1'b0;
        muldivresp_val        = 1'b1;
        muldivresp_msg_result = 64'h0000_0000_0000_0004;
        @(negedge clk);
        muldivresp_val = 1'b0;
        set_req(FN_MUL, 32'd2, 32'd2, 5'd8);
        @(negedge clk);
        cpureq_val = 1'b0;
        #1;
        check("pre_rst_val", cpuresp_val, 1);
        check("pre_rst_full", cpureq_rdy, 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_val", cpuresp_val, 0);
        check("async_rst_result", cpuresp_msg_result, 0);
        check("async_rst_tag", cpuresp_msg_tag, 0);
        check("async_rst_orphan", err_orphan, 0);
        check("async_rst_muldivresp_rdy", muldivresp_rdy, 0);
        check("async_rst_cpureq_rdy", cpureq_rdy, 1);
        @(negedge clk);
        reset         = 1'b1;
        muldivreq_rdy = 1'b0;
        #1;
        check("post_rst_cpureq_rdy_low", cpureq_rdy, 0);
        muldivreq_rdy = 1'b1;
        #1;
        check("post_rst_cpureq_rdy_high", cpureq_rdy, 1);
        @(posedge clk);
        #1;
        check("post_rst_val", cpuresp_val, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
